// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main control unit of the multicycle RV32I core.
// Moore state decode with Mealy gating of the fetch and branch enables.
module multicycle_control_fsm (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    state_t  state_q;
    state_t  state_d;
    alu_op_t alu_op;

    logic is_lw;
    logic is_sw;
    logic is_r;
    logic is_i;
    logic is_beq;
    logic op_legal;
    logic sub_sel;

    always_comb begin
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_r     = (op == OP_R);
        is_i     = (op == OP_I);
        is_beq   = (op == OP_BEQ);
        op_legal = is_lw | is_sw | is_r | is_i | is_beq;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: begin
                state_d = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                unique case (1'b1)
                    is_lw, is_sw: state_d = MEMADR;
                    is_r:         state_d = EXECUTER;
                    is_i:         state_d = EXECUTEI;
                    is_beq:       state_d = BEQ;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                state_d = is_lw ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                state_d = MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                state_d = FETCH;
            end
            MEMWRITE: begin
                state_d = MemReady ? FETCH : MEMWRITE;
            end
            EXECUTER, EXECUTEI: begin
                state_d = ALUWB;
            end
            ALUWB, BEQ: begin
                state_d = FETCH;
            end
            // encodings 10..15 recover to FETCH
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        Illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                Illegal = ~op_legal;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                alu_op  = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            BEQ: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = Zero;
            end
            default: begin
            end
        endcase

        // reset presents a quiet FETCH regardless of the held state
        if (!RST) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            Illegal   = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
            alu_op    = ALUOP_ADD;
        end
    end

    assign sub_sel = op[5] & funct7b5;

    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: begin
                ALUControl = ALU_SUB;
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = sub_sel ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: begin
                ALUControl = ALU_ADD;
            end
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        unique case (1'b1)
            is_sw:   ImmSrc = 2'b01;
            is_beq:  ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed vectors against an instruction-level
// model of the multicycle control unit, plus literal spot checks.
module tb_multicycle_control_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [6:0] op = IT;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       Illegal;
    logic [3:0] State;

    always #5 CLK = ~CLK;

    multicycle_control_fsm dut (
        .CLK(CLK), .RST(RST), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
    );

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       ill;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
        logic [3:0] st;
    } out_t;

    int tests = 0;
    int fails = 0;
    int pos = 0;

    int         st_log[$];
    bit         pcw_log[$];
    bit         irw_log[$];
    bit         rw_log[$];
    bit         mw_log[$];
    bit         ill_log[$];
    logic [2:0] alu_log[$];

    // an instruction is the list of states it walks through
    function automatic int seq_at(input logic [6:0] o, input int i);
        int s[5];
        case (o)
            LW:      s = '{0, 1, 2, 3, 4};
            SW:      s = '{0, 1, 2, 5, 0};
            RT:      s = '{0, 1, 6, 8, 0};
            IT:      s = '{0, 1, 7, 8, 0};
            BQ:      s = '{0, 1, 9, 0, 0};
            default: s = '{0, 1, 0, 0, 0};
        endcase
        return s[i];
    endfunction

    function automatic int seq_len(input logic [6:0] o);
        case (o)
            LW:           return 5;
            SW, RT, IT:   return 4;
            BQ:           return 3;
            default:      return 2;
        endcase
    endfunction

    function automatic bit mem_wait(input int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    always @(posedge CLK) begin
        if (!RST)
            pos <= 0;
        else if (mem_wait(seq_at(op, pos)) && !MemReady)
            pos <= pos;
        else if (pos + 1 == seq_len(op))
            pos <= 0;
        else
            pos <= pos + 1;
    end

    function automatic logic [2:0] funct_alu();
        case (funct3)
            3'b000:  return (op[5] && funct7b5) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic out_t model();
        out_t e;
        int   s;
        e = '0;
        s = seq_at(op, pos);
        e.st  = s[3:0];
        e.imm = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 : 2'd0;
        if (!RST) begin
            e.sb = 2'd2;
            e.rs = 2'd2;
            return e;
        end
        case (s)
            0: begin
                e.sb = 2'd2; e.rs = 2'd2;
                e.irw = MemReady; e.pcw = MemReady;
            end
            1: begin
                e.sa = 2'd1; e.sb = 2'd1;
                e.ill = !(op inside {LW, SW, RT, IT, BQ});
            end
            2: begin e.sa = 2'd2; e.sb = 2'd1; end
            3: e.adr = 1'b1;
            4: begin e.rs = 2'd1; e.rw = 1'b1; end
            5: begin e.adr = 1'b1; e.mw = 1'b1; end
            6: begin e.sa = 2'd2; e.alu = funct_alu(); end
            7: begin e.sa = 2'd2; e.sb = 2'd1; e.alu = funct_alu(); end
            8: e.rw = 1'b1;
            9: begin e.sa = 2'd2; e.alu = 3'd1; e.pcw = Zero; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(input logic mr);
        out_t got;
        out_t exp;
        MemReady = mr;
        @(negedge CLK);
        got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State};
        exp = model();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL cycle t=%0t op=%b outputs got %h want %h",
                     $time, op, got, exp);
        end
        st_log.push_back(int'(State));
        pcw_log.push_back(PCWrite);
        irw_log.push_back(IRWrite);
        rw_log.push_back(RegWrite);
        mw_log.push_back(MemWrite);
        ill_log.push_back(Illegal);
        alu_log.push_back(ALUControl);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int cnt(input bit q[$]);
        int n = 0;
        foreach (q[i]) n += int'(q[i]);
        return n;
    endfunction

    task automatic run(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z,
                       input logic [15:0] pat, input int n);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        st_log.delete(); pcw_log.delete(); irw_log.delete();
        rw_log.delete(); mw_log.delete(); ill_log.delete();
        alu_log.delete();
        for (int i = 0; i < n; i++) step(pat[i]);
    endtask

    initial begin
        RST = 1'b0;
        MemReady = 1'b1;
        @(posedge CLK);
        #1;
        step(1'b1);
        step(1'b1);
        chk("rst_state", st_log[1], 0);
        chk("rst_irw", cnt(irw_log), 0);
        chk("rst_pcw", cnt(pcw_log), 0);
        RST = 1'b1;

        run(LW, 3'b010, 1'b0, 1'b0, 16'hFFFF, 5);
        for (int i = 0; i < 5; i++) chk("lw_seq", st_log[i], i);
        chk("lw_fetch_irw", int'(irw_log[0]), 1);
        chk("lw_fetch_pcw", int'(pcw_log[0]), 1);
        chk("lw_rw_wb", int'(rw_log[4]), 1);
        chk("lw_rw_cnt", cnt(rw_log), 1);
        chk("lw_back", int'(State), 0);

        run(SW, 3'b010, 1'b0, 1'b0, 16'h0047, 7);
        chk("sw_mw_cnt", cnt(mw_log), 4);
        chk("sw_imm", int'(ImmSrc), 1);
        chk("sw_back", int'(State), 0);

        run(RT, 3'b000, 1'b1, 1'b0, 16'hFFFF, 4);
        chk("r_sub", int'(alu_log[2]), 1);
        chk("r_wb", int'(rw_log[3]), 1);
        run(RT, 3'b010, 1'b0, 1'b0, 16'hFFFF, 4);
        chk("r_slt", int'(alu_log[2]), 5);
        run(RT, 3'b110, 1'b0, 1'b0, 16'hFFFF, 4);
        chk("r_or", int'(alu_log[2]), 3);
        run(RT, 3'b111, 1'b0, 1'b0, 16'hFFFF, 4);
        chk("r_and", int'(alu_log[2]), 2);

        run(IT, 3'b000, 1'b1, 1'b0, 16'hFFFE, 5);
        chk("i_stall", st_log[1], 0);
        chk("i_exec", st_log[3], 7);
        chk("i_addi", int'(alu_log[3]), 0);

        run(BQ, 3'b000, 1'b0, 1'b1, 16'hFFFF, 3);
        chk("beq_t_pcw", int'(pcw_log[2]), 1);
        chk("beq_t_cnt", cnt(pcw_log), 2);
        chk("beq_t_back", int'(State), 0);
        run(BQ, 3'b000, 1'b0, 1'b0, 16'hFFFF, 3);
        chk("beq_n_pcw", int'(pcw_log[2]), 0);
        chk("beq_n_back", int'(State), 0);

        run(BAD, 3'b000, 1'b0, 1'b0, 16'hFFFF, 2);
        chk("ill_pulse", int'(ill_log[1]), 1);
        chk("ill_cnt", cnt(ill_log), 1);
        chk("ill_back", int'(State), 0);

        run(LW, 3'b010, 1'b0, 1'b0, 16'h0007, 5);
        chk("lw_stall", int'(State), 3);
        RST = 1'b0;
        step(1'b0);
        RST = 1'b1;
        chk("rst_stall", int'(State), 0);
        chk("rst_no_rw", cnt(rw_log), 0);

        run(SW, 3'b010, 1'b0, 1'b0, 16'hFFFF, 4);
        chk("sw_fast_mw", cnt(mw_log), 1);
        run(LW, 3'b010, 1'b0, 1'b0, 16'h0037, 6);
        chk("lw_wait_wb", st_log[5], 4);
        chk("lw_wait_back", int'(State), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
